// File: rtl/tb_uart_stim_tx.sv
// tb_uart_stim_tx: FIFO-fed 8N1 UART transmitter driving serial stimulus.
// Optional even parity bit enabled by defining TB_UART_STIM_PARITY_EN.
module tb_uart_stim_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int STOP_BITS    = 1,
  parameter int GAP_CYCLES   = 0
) (
  input  logic                          CLK,
  input  logic                          RESETn,
  input  logic [7:0]                    TX_DATA,
  input  logic                          TX_VALID,
`ifdef TB_UART_STIM_PARITY_EN
  input  logic                          PARITY_ERR_INJ,
`endif
  output logic                          TX_READY,
  output logic                          TXD,
  output logic                          BUSY,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
  output logic                          BYTE_DONE
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [GW-1:0] GAP_LAST  =
    GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [LW-1:0] FULL      = LW'(FIFO_DEPTH);
  localparam bit            HAS_GAP   = (GAP_CYCLES > 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_GAP
  } state_e;

  state_e        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [7:0]    shift_q, shift_d;
`ifdef TB_UART_STIM_PARITY_EN
  logic          par_q, par_d;
`endif

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [LW-1:0] lvl_q;

  logic          push;
  logic          pop;
  logic          tick;
  logic          last_stop;
  logic [7:0]    head;

  assign TX_READY   = (lvl_q != FULL);
  assign push       = TX_VALID && TX_READY;
  assign head       = mem_q[rd_q];
  assign tick       = (baud_q == BAUD_LAST);
  assign last_stop  = (bit_q == STOP_LAST);
  assign FIFO_LEVEL = lvl_q;
  assign BUSY       = (state_q != S_IDLE) || (lvl_q != '0);

  // FIFO storage; contents need no reset, only the pointers do
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_q] <= TX_DATA;
    end
  end

  // FIFO pointers and fill level; pointers wrap modulo depth
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      if (push) begin
        wr_q <= wr_q + PW'(1);
      end
      if (pop) begin
        rd_q <= rd_q + PW'(1);
      end
      if (push && !pop) begin
        lvl_q <= lvl_q + LW'(1);
      end else if (pop && !push) begin
        lvl_q <= lvl_q - LW'(1);
      end
    end
  end

  // FSM state, baud/bit/gap counters and shift register
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      shift_q <= '0;
`ifdef TB_UART_STIM_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      shift_q <= shift_d;
`ifdef TB_UART_STIM_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next-state logic: sequence one frame, pop the next byte from IDLE
  always_comb begin
    state_d = state_q;
    baud_d  = tick ? '0 : baud_q + BW'(1);
    bit_d   = bit_q;
    gap_d   = gap_q;
    shift_d = shift_q;
`ifdef TB_UART_STIM_PARITY_EN
    par_d   = par_q;
`endif
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (lvl_q != '0) begin
          pop     = 1'b1;
          shift_d = head;
`ifdef TB_UART_STIM_PARITY_EN
          par_d   = (^head) ^ PARITY_ERR_INJ;
`endif
          state_d = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (tick) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef TB_UART_STIM_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef TB_UART_STIM_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
          if (last_stop) begin
            bit_d   = '0;
            state_d = HAS_GAP ? S_GAP : S_IDLE;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      S_GAP: begin
        baud_d = '0;
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: begin
        baud_d  = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs: serial line level and end-of-frame pulse
  always_comb begin
    TXD       = 1'b1;
    BYTE_DONE = 1'b0;
    unique case (state_q)
      S_START: TXD = 1'b0;
      S_DATA:  TXD = shift_q[0];
`ifdef TB_UART_STIM_PARITY_EN
      S_PARITY: TXD = par_q;
`endif
      S_STOP:  BYTE_DONE = tick && last_stop && !HAS_GAP;
      S_GAP:   BYTE_DONE = (gap_q == GAP_LAST);
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tb_uart_stim_tx.sv
// tb_tb_uart_stim_tx: scenario tasks plus a serial RX scoreboard.
// Parity scenario only with TB_UART_STIM_PARITY_EN defined.
module tb_tb_uart_stim_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;
`ifdef TB_UART_STIM_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int DONE1 = 2 + (10 + PB) * CPB - 1;
  localparam int FP0   = (10 + PB) * CPB + 1;
  localparam int FP1   = (11 + PB) * CPB + 3 + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] d0 = '0;
  logic [7:0] d1 = '0;
  logic v0 = 1'b0;
  logic v1 = 1'b0;
  logic inj0 = 1'b0;
  logic inj1 = 1'b0;
  logic rdy0, txd0, busy0, done0;
  logic rdy1, txd1, busy1, done1;
  logic [LW-1:0] lvl0, lvl1;

  int n_tests = 0;
  int n_fail = 0;
  logic [8:0] sb[$];
  logic mon_abort = 1'b0;

  always #5 clk = ~clk;

  tb_uart_stim_tx #(
    .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH),
    .STOP_BITS(1), .GAP_CYCLES(0)
  ) u0 (
    .CLK(clk), .RESETn(rst_n),
    .TX_DATA(d0), .TX_VALID(v0),
`ifdef TB_UART_STIM_PARITY_EN
    .PARITY_ERR_INJ(inj0),
`endif
    .TX_READY(rdy0), .TXD(txd0), .BUSY(busy0),
    .FIFO_LEVEL(lvl0), .BYTE_DONE(done0)
  );

  tb_uart_stim_tx #(
    .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH),
    .STOP_BITS(2), .GAP_CYCLES(3)
  ) u1 (
    .CLK(clk), .RESETn(rst_n),
    .TX_DATA(d1), .TX_VALID(v1),
`ifdef TB_UART_STIM_PARITY_EN
    .PARITY_ERR_INJ(inj1),
`endif
    .TX_READY(rdy1), .TXD(txd1), .BUSY(busy1),
    .FIFO_LEVEL(lvl1), .BYTE_DONE(done1)
  );

  // expected line level at offset 'off' from the start bit
  function automatic logic frame_bit(int off, logic [7:0] b,
                                     logic inj);
    if (off < 0) return 1'b1;
    if (off < CPB) return 1'b0;
    if (off < 9 * CPB) return b[(off - CPB) / CPB];
    if (PB != 0 && off < 10 * CPB) return (^b) ^ inj;
    return 1'b1;
  endfunction

  task automatic mon_wait(int n);
    repeat (n) begin
      @(negedge clk);
      if (!rst_n) mon_abort = 1'b1;
    end
  endtask

  // serial receiver on u0 TXD, mid-bit sampling, pops the scoreboard
  initial begin : monitor
    logic [7:0] b;
    logic p, s;
    logic [8:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && txd0 === 1'b0) begin
        mon_abort = 1'b0;
        mon_wait(CPB / 2);
        for (int i = 0; i < 8; i++) begin
          mon_wait(CPB);
          b[i] = txd0;
        end
        p = 1'b0;
        if (PB != 0) begin
          mon_wait(CPB);
          p = txd0;
        end
        mon_wait(CPB);
        s = txd0;
        if (!mon_abort) begin
          n_tests++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL rx_unexpected got %02h required none", b);
          end else begin
            e = sb.pop_front();
            if (b !== e[7:0] || s !== 1'b1 ||
                (PB != 0 && p !== ((^e[7:0]) ^ e[8]))) begin
              n_fail++;
              $display("FAIL rx_byte got %02h p%b s%b required %02h p%b s1",
                       b, p, s, e[7:0], (^e[7:0]) ^ e[8]);
            end
          end
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    v0 = 1'b0;
    v1 = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({txd0, rdy0, busy0, done0, lvl0} !== {4'b1100, LW'(0)}) begin
      n_fail++;
      $display("FAIL reset_hold got %b required %b",
               {txd0, rdy0, busy0, done0, lvl0}, {4'b1100, LW'(0)});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({txd0, rdy0, busy0, done0, lvl0} !== {4'b1100, LW'(0)}) begin
      n_fail++;
      $display("FAIL reset_u0 got %b required %b",
               {txd0, rdy0, busy0, done0, lvl0}, {4'b1100, LW'(0)});
    end
    n_tests++;
    if ({txd1, rdy1, busy1, done1, lvl1} !== {4'b1100, LW'(0)}) begin
      n_fail++;
      $display("FAIL reset_u1 got %b required %b",
               {txd1, rdy1, busy1, done1, lvl1}, {4'b1100, LW'(0)});
    end
  endtask

  task automatic test_single();
    logic et, ed, eb;
    for (int k = 0; k <= DONE1 + 1; k++) begin
      et = frame_bit(k - 2, 8'h55, 1'b0);
      ed = (k == DONE1);
      eb = (k >= 1 && k <= DONE1);
      n_tests++;
      if ({txd0, done0, busy0} !== {et, ed, eb}) begin
        n_fail++;
        $display("FAIL single_0x55 k=%0d got txd/done/busy %b required %b",
                 k, {txd0, done0, busy0}, {et, ed, eb});
      end
      if (k == 0) begin
        d0 = 8'h55;
        v0 = 1'b1;
        sb.push_back({1'b0, 8'h55});
      end else begin
        v0 = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_fifo_full();
    int i = 0;
    int full_t = -1;
    int t;
    int dn[$];
    for (t = 0; t < 600 && dn.size() < 6; t++) begin
      if (done0) dn.push_back(t);
      if (i == 5 && full_t < 0) begin
        full_t = t;
        n_tests++;
        if ({rdy0, lvl0} !== {1'b0, LW'(4)}) begin
          n_fail++;
          $display("FAIL fifo_full got rdy/lvl %b required %b",
                   {rdy0, lvl0}, {1'b0, LW'(4)});
        end
      end
      if (i < 6) begin
        d0 = 8'(i + 1);
        v0 = 1'b1;
        if (rdy0) begin
          sb.push_back({1'b0, d0});
          i++;
        end
      end else begin
        v0 = 1'b0;
      end
      @(negedge clk);
    end
    v0 = 1'b0;
    n_tests++;
    if (dn.size() != 6 || i != 6 || full_t != 5) begin
      n_fail++;
      $display("FAIL fifo_progress got done=%0d pushed=%0d full_at=%0d required 6 6 5",
               dn.size(), i, full_t);
    end
    if (dn.size() == 6) begin
      n_tests++;
      if (dn[0] != DONE1) begin
        n_fail++;
        $display("FAIL fifo_first_done got %0d required %0d", dn[0], DONE1);
      end
      for (int j = 1; j < 6; j++) begin
        n_tests++;
        if (dn[j] - dn[j-1] != FP0) begin
          n_fail++;
          $display("FAIL fifo_period%0d got %0d required %0d",
                   j, dn[j] - dn[j-1], FP0);
        end
      end
    end
  endtask

  task automatic test_stop_gap();
    logic et, ed;
    for (int k = 0; k <= 2 * FP1 + 1; k++) begin
      et = (k >= 2 + FP1) ? frame_bit(k - 2 - FP1, 8'h3C, 1'b0)
                          : frame_bit(k - 2, 8'hA5, 1'b0);
      ed = (k == FP1) || (k == 2 * FP1);
      n_tests++;
      if ({txd1, done1} !== {et, ed}) begin
        n_fail++;
        $display("FAIL stop_gap k=%0d got txd/done %b required %b",
                 k, {txd1, done1}, {et, ed});
      end
      if (k == 0) begin
        d1 = 8'hA5;
        v1 = 1'b1;
      end else if (k == 1) begin
        d1 = 8'h3C;
      end else begin
        v1 = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    for (int k = 0; k < 20; k++) begin
      if (done0 !== 1'b0) bad++;
      if (k == 19) begin
        n_tests++;
        if ({lvl0, txd0} !== {LW'(2), 1'b0}) begin
          n_fail++;
          $display("FAIL mid_before got lvl/txd %b required %b",
                   {lvl0, txd0}, {LW'(2), 1'b0});
        end
        rst_n = 1'b0;
      end
      if (k == 0) begin
        d0 = 8'hF0;
        v0 = 1'b1;
      end else if (k == 1) begin
        d0 = 8'hAA;
      end else if (k == 2) begin
        d0 = 8'hBB;
      end else begin
        v0 = 1'b0;
      end
      @(negedge clk);
    end
    n_tests++;
    if ({txd0, rdy0, busy0, done0, lvl0} !== {4'b1100, LW'(0)}) begin
      n_fail++;
      $display("FAIL mid_reset got %b required %b",
               {txd0, rdy0, busy0, done0, lvl0}, {4'b1100, LW'(0)});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (txd0 !== 1'b1 || done0 !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL mid_quiet got %0d bad cycles required 0", bad);
    end
  endtask

  task automatic test_loopback();
    logic [7:0] lb [4];
    int i = 0;
    int t;
    lb = '{8'h00, 8'hFF, 8'h1B, 8'h11};
    for (t = 0; t < 800 && (i < 4 || sb.size() != 0); t++) begin
      if (i < 4) begin
        d0 = lb[i];
        v0 = 1'b1;
        if (rdy0) begin
          sb.push_back({1'b0, lb[i]});
          i++;
        end
      end else begin
        v0 = 1'b0;
      end
      @(negedge clk);
    end
    v0 = 1'b0;
    n_tests++;
    if (i != 4 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL loopback_drain got pushed=%0d pending=%0d required 4 0",
               i, sb.size());
    end
    repeat (3) @(negedge clk);
    n_tests++;
    if ({busy0, lvl0} !== {1'b0, LW'(0)}) begin
      n_fail++;
      $display("FAIL loopback_idle got busy/lvl %b required %b",
               {busy0, lvl0}, {1'b0, LW'(0)});
    end
  endtask

`ifdef TB_UART_STIM_PARITY_EN
  task automatic par_frame(logic inj, logic exp_p);
    int dt = -1;
    for (int k = 0; k <= DONE1 + 2; k++) begin
      if (k == 2 + 9 * CPB + CPB / 2) begin
        n_tests++;
        if (txd0 !== exp_p) begin
          n_fail++;
          $display("FAIL parity_bit inj=%b got %b required %b",
                   inj, txd0, exp_p);
        end
      end
      if (done0 && dt < 0) dt = k;
      if (k == 0) begin
        d0 = 8'h07;
        v0 = 1'b1;
        inj0 = inj;
        sb.push_back({inj, 8'h07});
      end else if (k == 1) begin
        v0 = 1'b0;
      end else begin
        inj0 = 1'b0;
      end
      @(negedge clk);
    end
    n_tests++;
    if (dt != DONE1) begin
      n_fail++;
      $display("FAIL parity_len got done at %0d required %0d", dt, DONE1);
    end
  endtask

  task automatic test_parity();
    par_frame(1'b0, 1'b1);
    par_frame(1'b1, 1'b0);
  endtask
`endif

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : main
    test_reset();
    test_single();
    test_fifo_full();
    test_stop_gap();
    test_reset_mid();
    test_loopback();
`ifdef TB_UART_STIM_PARITY_EN
    test_parity();
`endif
    repeat (5) @(negedge clk);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover got %0d pending required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tb_uart_stim_tx.md
Name: tb_uart_stim_tx

Overview:
Testbench-side UART transmitter that drives serial stimulus into the MCU UART receive pin, e.g. P1[0] for UART0 RXD when the crossover is disabled.
- Bench code or a script-driven task pushes bytes through a valid/ready port into a small FIFO.
- The block serialises them 8N1, LSB first, at a fixed clocks-per-bit rate.
- It mirrors the UART capture device on P1[5], giving the bench a synthesizable-style stimulus source for UART RX tests.

Parameters:
- CLKS_PER_BIT, 16: clock cycles per serial bit (>=2).
- FIFO_DEPTH, 4: byte FIFO entries; power of 2, >=2.
- STOP_BITS, 1: number of stop bits (1 or 2).
- GAP_CYCLES, 0: extra idle-high cycles inserted after the stop bit(s) before the next start bit.

Ports:
- CLK, input, 1: clock (same clock as the UART capture PCLK).
- RESETn, input, 1: synchronous active-low reset.
- TX_DATA, input, 8: byte to send.
- TX_VALID, input, 1: TX_DATA valid.
- TX_READY, output, 1: FIFO can accept a byte.
- TXD, output, 1: serial output, idle high.
- BUSY, output, 1: a frame is in progress or the FIFO is non-empty.
- FIFO_LEVEL, output, $clog2(FIFO_DEPTH)+1: number of bytes queued, excluding the byte in flight.
- BYTE_DONE, output, 1: one-cycle pulse at the end of the last stop bit (or the end of the gap, if GAP_CYCLES>0).

Behaviour:
- Reset is synchronous and active-low on CLK; all state is updated only on the rising edge of CLK.
- Reset values:
  - TXD=1, TX_READY=1, BUSY=0, FIFO_LEVEL=0, BYTE_DONE=0.
  - FIFO pointers 0; FSM in IDLE; bit and baud counters 0.
- Push: occurs on a cycle where TX_VALID && TX_READY.
  - TX_READY = (FIFO_LEVEL != FIFO_DEPTH); it is combinational from registered level.
  - TX_DATA need only be stable in the push cycle.
  - TX_VALID while full is ignored, with no overflow side effect.
- Pop: in IDLE, when FIFO_LEVEL>0, the FSM pops the head byte into the shift register and enters START in the next cycle.
- Simultaneous push and pop in one cycle: level unchanged, both take effect.
  - Push into an empty FIFO in IDLE: the byte is popped the following cycle.
  - Latency from push to TXD falling is 2 cycles.
- FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> [GAP] -> IDLE.
  - IDLE: TXD=1; baud counter held at 0.
  - START: TXD=0 for CLKS_PER_BIT cycles.
  - DATA: TXD=shift[0] for CLKS_PER_BIT cycles per bit; shift right after each bit; exactly 8 bits, counted by a 3-bit counter that wraps 7->0 on exit.
  - STOP: TXD=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - GAP: TXD=1 for GAP_CYCLES cycles; the state is skipped if GAP_CYCLES=0.
- Baud counter: counts 0..CLKS_PER_BIT-1. A state or bit advances when count==CLKS_PER_BIT-1; the counter then returns to 0. No drift is accumulated across frames.
- BYTE_DONE: asserted in the final cycle of STOP (or of GAP, if present); FSM in IDLE the next cycle.
- Back-to-back frames:
  - The IDLE dwell between frames is exactly 1 cycle.
  - Frame period = (1+8+STOP_BITS)*CLKS_PER_BIT + GAP_CYCLES + 1 cycles.
- BUSY = (state != IDLE) || (FIFO_LEVEL != 0).
- Reset mid-frame (RESETn low at an edge):
  - TXD returns to 1 at that edge.
  - The FIFO is flushed and the partial frame is abandoned.
  - No BYTE_DONE is generated.
- FIFO pointers wrap modulo FIFO_DEPTH.

Optional Feature:
- Macro: TB_UART_STIM_PARITY_EN.
- When defined:
  - A PARITY state follows DATA and lasts CLKS_PER_BIT cycles.
  - TXD = XOR of the 8 data bits (even parity) during PARITY.
  - An extra input PARITY_ERR_INJ (1 bit), sampled at the pop, inverts the parity bit of that frame.
  - Frame period grows by CLKS_PER_BIT.
- When undefined: no PARITY state and no PARITY_ERR_INJ port; frames are strict 8N1.

Test Plan:
- CLKS_PER_BIT=4, GAP_CYCLES=0: reset, push 0x55.
  - TXD falls 2 cycles after the push.
  - TXD then shows 0,1,0,1,0,1,0,1,0 (start + LSB-first data), then 1, each level held 4 cycles.
  - BYTE_DONE pulses once at cycle 2+40-1.
  - BUSY=0 from the cycle after the pulse.
- FIFO_DEPTH=4: push 6 bytes (0x01..0x06) with TX_VALID held.
  - 5 pushes accepted (1 popped, 4 queued); TX_READY=0 and FIFO_LEVEL=4.
  - 0x06 is held until READY rises, then accepted.
  - All 6 bytes appear in order on TXD, each frame period 41 cycles.
- STOP_BITS=2, GAP_CYCLES=3, CLKS_PER_BIT=4: push 0xA5, 0x3C back-to-back.
  - Stop high for 8 cycles plus gap of 3.
  - Next start bit exactly 12 cycles after the last data bit ends.
- Assert RESETn low in the middle of data bit 3 of 0xF0 with 2 bytes queued.
  - TXD=1 at that edge; FIFO_LEVEL=0, TX_READY=1, BUSY=0.
  - No BYTE_DONE; after release, TXD idles high.
- Loopback: connect TXD to a UART RX with a matching divider; send 0x00, 0xFF, 0x1B, 0x11 and require identical received bytes.
- With TB_UART_STIM_PARITY_EN: send 0x07, then 0x07 with PARITY_ERR_INJ=1.
  - First frame: parity bit 1.
  - Second frame: parity bit 0.
  - Frame length 44 cycles at CLKS_PER_BIT=4.
